seg_disp_arbiter: RTL and testbench

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

---
 rtl/seg_disp_arbiter.sv | 128 ++++++++++++
 tb/tb_seg_disp_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Display-ownership arbiter: the CPU and the switch echo compete for one
// 8-digit display; the CPU always wins and a single switch value may wait.
module seg_disp_arbiter #(
    parameter int HOLD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_data,
    input  logic        sw_req,
    input  logic [15:0] sw_data,
    output logic [31:0] disp_data,
    output logic        disp_we,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        dropped
);

    localparam int CNT_W = $clog2(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CPU_HOLD = 2'b01,
        SW_HOLD  = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [15:0]      pending, pend_nxt;
    logic             pend_valid, pv_nxt;
    logic [31:0]      data_nxt;
    logic             we_nxt, drop_nxt;

    function automatic logic [31:0] zext(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            pending    <= 16'h0;
            pend_valid <= 1'b0;
            disp_data  <= 32'h0;
            disp_we    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= cnt_nxt;
            pending    <= pend_nxt;
            pend_valid <= pv_nxt;
            disp_data  <= data_nxt;
            disp_we    <= we_nxt;
            dropped    <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        pend_nxt  = pending;
        pv_nxt    = pend_valid;
        data_nxt  = disp_data;
        we_nxt    = 1'b0;
        drop_nxt  = 1'b0;

        if (cpu_req) begin
            // CPU preempts from any state; a simultaneous switch strobe is parked.
            state_nxt = CPU_HOLD;
            cnt_nxt   = CNT_LOAD;
            data_nxt  = cpu_data;
            we_nxt    = 1'b1;
            if (sw_req) begin
                pend_nxt = sw_data;
                pv_nxt   = 1'b1;
                drop_nxt = pend_valid;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (sw_req) begin
                        state_nxt = SW_HOLD;
                        cnt_nxt   = CNT_LOAD;
                        data_nxt  = zext(sw_data);
                        we_nxt    = 1'b1;
                    end
                end
                SW_HOLD: begin
                    if (sw_req) begin
                        cnt_nxt  = CNT_LOAD;
                        data_nxt = zext(sw_data);
                        we_nxt   = 1'b1;
                    end else if (hold_cnt != '0) begin
                        cnt_nxt = hold_cnt - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                CPU_HOLD: begin
                    if (hold_cnt != '0) begin
                        cnt_nxt = hold_cnt - CNT_W'(1);
                        if (sw_req) begin
                            pend_nxt = sw_data;
                            pv_nxt   = 1'b1;
                            drop_nxt = pend_valid;
                        end
                    end else if (sw_req || pend_valid) begin
                        // Expiry hands the display to the newest waiting switch value.
                        state_nxt = SW_HOLD;
                        cnt_nxt   = CNT_LOAD;
                        data_nxt  = zext(sw_req ? sw_data : pending);
                        we_nxt    = 1'b1;
                        pv_nxt    = 1'b0;
                        drop_nxt  = sw_req && pend_valid;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign grant = state;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with HOLD_CYC=4: vector table plus
// hand-written reset sequences.
module tb_seg_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_data;
    logic        sw_req;
    logic [15:0] sw_data;
    logic [31:0] disp_data;
    logic        disp_we;
    logic [1:0]  grant;
    logic        busy;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_disp_arbiter #(.HOLD_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_data  (cpu_data),
        .sw_req    (sw_req),
        .sw_data   (sw_data),
        .disp_data (disp_data),
        .disp_we   (disp_we),
        .grant     (grant),
        .busy      (busy),
        .dropped   (dropped)
    );

    typedef struct {
        logic        cpu_req;
        logic [31:0] cpu_data;
        logic        sw_req;
        logic [15:0] sw_data;
        logic [31:0] e_data;
        logic        e_we;
        logic [1:0]  e_grant;
        logic        e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic [31:0] cd, input logic s,
                                input logic [15:0] sd, input logic [31:0] ed,
                                input logic ew, input logic [1:0] eg, input logic edr);
        vec_t v;
        v.cpu_req = c;  v.cpu_data = cd; v.sw_req = s;  v.sw_data = sd;
        v.e_data  = ed; v.e_we     = ew; v.e_grant = eg; v.e_drop = edr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ed, input logic ew,
                             input logic [1:0] eg, input logic edr);
        check({tag, " disp_data"}, disp_data, ed);
        check({tag, " disp_we"}, {31'b0, disp_we}, {31'b0, ew});
        check({tag, " grant"}, {30'b0, grant}, {30'b0, eg});
        check({tag, " busy"}, {31'b0, busy}, {31'b0, (eg != 2'b00)});
        check({tag, " dropped"}, {31'b0, dropped}, {31'b0, edr});
    endtask

    task automatic step(input logic c, input logic [31:0] cd, input logic s, input logic [15:0] sd);
        cpu_req = c; cpu_data = cd; sw_req = s; sw_data = sd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_data = 32'h0; sw_req = 1'b0; sw_data = 16'h0;

        // Cpu grant, hold of 4 cycles, return to idle
        vecs.push_back(mk(1, 32'h1234ABCD, 0, 16'h0, 32'h1234ABCD, 1, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h1234ABCD, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h1234ABCD, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h1234ABCD, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h1234ABCD, 0, 2'b00, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h1234ABCD, 0, 2'b00, 0));
        // Simultaneous requests: switch value waits, shown at expiry
        vecs.push_back(mk(1, 32'h11112222, 1, 16'h00FF, 32'h11112222, 1, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h11112222, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h11112222, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h11112222, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h000000FF, 1, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h000000FF, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h000000FF, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h000000FF, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h000000FF, 0, 2'b00, 0));
        // Pending overwrite pulses dropped, last value shown
        vecs.push_back(mk(1, 32'hAAAA5555, 0, 16'h0, 32'hAAAA5555, 1, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 1, 16'h0001, 32'hAAAA5555, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 1, 16'h0002, 32'hAAAA5555, 0, 2'b01, 1));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hAAAA5555, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000002, 1, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000002, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000002, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000002, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000002, 0, 2'b00, 0));
        // Cpu preempts switch hold; switch value is not redisplayed
        vecs.push_back(mk(0, 32'h0, 1, 16'h0005, 32'h00000005, 1, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000005, 0, 2'b10, 0));
        vecs.push_back(mk(1, 32'hDEADBEEF, 0, 16'h0, 32'hDEADBEEF, 1, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hDEADBEEF, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hDEADBEEF, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hDEADBEEF, 0, 2'b01, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hDEADBEEF, 0, 2'b00, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'hDEADBEEF, 0, 2'b00, 0));
        // Switch refresh during switch hold reloads the counter
        vecs.push_back(mk(0, 32'h0, 1, 16'h0010, 32'h00000010, 1, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000010, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 1, 16'h0020, 32'h00000020, 1, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000020, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000020, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000020, 0, 2'b10, 0));
        vecs.push_back(mk(0, 32'h0, 0, 16'h0, 32'h00000020, 0, 2'b00, 0));

        // Reset held for 10 cycles with idle inputs
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("reset%0d", i), 32'h0, 1'b0, 2'b00, 1'b0);
        end
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cpu_req, vecs[i].cpu_data, vecs[i].sw_req, vecs[i].sw_data);
            check_all($sformatf("row%0d", i), vecs[i].e_data, vecs[i].e_we,
                      vecs[i].e_grant, vecs[i].e_drop);
        end

        // Asynchronous reset during CPU hold with a pending switch value
        step(1'b1, 32'h0BADF00D, 1'b0, 16'h0);
        check_all("midrst grant", 32'h0BADF00D, 1'b1, 2'b01, 1'b0);
        step(1'b0, 32'h0, 1'b1, 16'h0007);
        check_all("midrst pend", 32'h0BADF00D, 1'b0, 2'b01, 1'b0);
        cpu_req = 1'b0; sw_req = 1'b0; sw_data = 16'h0;
        #2;
        rst = 1'b0;
        #1;
        check_all("async rst", 32'h0, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst held", 32'h0, 1'b0, 2'b00, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0, 16'h0);
            check_all($sformatf("post rst%0d", i), 32'h0, 1'b0, 2'b00, 1'b0);
        end

        // First edge after release behaves as idle: switch strobe is granted
        step(1'b0, 32'h0, 1'b1, 16'h0033);
        check_all("post rst sw", 32'h00000033, 1'b1, 2'b10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
